// File: rtl/control_unit_if.sv
// Datapath <-> control unit signal bundle; master = control unit, slave = datapath.
// Optional imem_ready handshake is present only when CU_IMEM_WAIT_EN is defined.
interface control_unit_if #(
    parameter int ICNT_W = 16
);
    // Datapath to control unit
    logic [3:0]        opcode_in;
    logic [2:0]        rd_addr_in;
    logic              zero_flag_in;
    logic              negative_flag_in;
`ifdef CU_IMEM_WAIT_EN
    logic              imem_ready;
`endif

    // Control unit to datapath / status
    logic              pc_write_enable;
    logic [1:0]        pc_source_sel;
    logic              ir_write_enable;
    logic              rf_write_enable;
    logic [2:0]        rf_write_dest_sel_addr;
    logic [1:0]        rf_write_data_sel;
    logic [2:0]        alu_op_sel;
    logic              alu_b_src_sel;
    logic              halted;
    logic              illegal_op;
    logic              z_flag;
    logic              n_flag;
    logic [ICNT_W-1:0] instr_count;

    modport master (
`ifdef CU_IMEM_WAIT_EN
        input  imem_ready,
`endif
        input  opcode_in, rd_addr_in, zero_flag_in, negative_flag_in,
        output pc_write_enable, pc_source_sel, ir_write_enable, rf_write_enable,
        output rf_write_dest_sel_addr, rf_write_data_sel, alu_op_sel, alu_b_src_sel,
        output halted, illegal_op, z_flag, n_flag, instr_count
    );

    modport slave (
`ifdef CU_IMEM_WAIT_EN
        output imem_ready,
`endif
        output opcode_in, rd_addr_in, zero_flag_in, negative_flag_in,
        input  pc_write_enable, pc_source_sel, ir_write_enable, rf_write_enable,
        input  rf_write_dest_sel_addr, rf_write_data_sel, alu_op_sel, alu_b_src_sel,
        input  halted, illegal_op, z_flag, n_flag, instr_count
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer driving every datapath control strobe.
// Define CU_IMEM_WAIT_EN to stall FETCH on the instruction-memory imem_ready input.
module control_unit #(
    parameter logic [2:0] LR_ADDR = 3'd7,
    parameter int         ICNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master cu
);

    // S_IDLE is the reset-pending state, so the first FETCH lands one edge after release.
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LOAD = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
        OP_XOR  = 4'h4, OP_CMP  = 4'h5, OP_BEQ = 4'h6, OP_BLT = 4'h7,
        OP_JMP  = 4'h8, OP_CALL = 4'h9, OP_RET = 4'hA, OP_HALT = 4'hF
    } opcode_e;

    state_e            state_q, state_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              ill_q, ill_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;

    logic       pc_we, ir_we, rf_we, b_src;
    logic [1:0] pc_sel, data_sel;
    logic [2:0] alu_op, dest;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        n_d      = n_q;
        ill_d    = ill_q;
        icnt_d   = icnt_q;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        b_src    = 1'b0;
        pc_sel   = 2'b00;
        data_sel = 2'b00;
        alu_op   = 3'b000;
        dest     = cu.rd_addr_in;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
`ifdef CU_IMEM_WAIT_EN
                if (cu.imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
`else
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
`endif
            end
            S_DECODE: state_d = (cu.opcode_in == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_FETCH;
                icnt_d  = icnt_q + 1'b1;
                case (cu.opcode_in)
                    OP_NOP, OP_HALT: ;
                    OP_LOAD: begin rf_we = 1'b1; data_sel = 2'b01; end
                    OP_MOV:  begin rf_we = 1'b1; alu_op = 3'b010; end
                    OP_ADD:  begin rf_we = 1'b1; alu_op = 3'b000; end
                    OP_XOR:  begin rf_we = 1'b1; alu_op = 3'b001; end
                    OP_CMP: begin
                        alu_op = 3'b011;
                        z_d    = cu.zero_flag_in;
                        n_d    = cu.negative_flag_in;
                    end
                    OP_BEQ: if (z_q) begin pc_we = 1'b1; pc_sel = 2'b01; end
                    OP_BLT: if (n_q) begin pc_we = 1'b1; pc_sel = 2'b01; end
                    OP_JMP:  begin pc_we = 1'b1; pc_sel = 2'b01; end
                    // LR captures the current PC while the PC loads the call target.
                    OP_CALL: begin
                        rf_we    = 1'b1;
                        dest     = LR_ADDR;
                        data_sel = 2'b10;
                        pc_we    = 1'b1;
                        pc_sel   = 2'b11;
                    end
                    OP_RET:  begin pc_we = 1'b1; pc_sel = 2'b10; end
                    default: ill_d = 1'b1;
                endcase
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            ill_q   <= 1'b0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            n_q     <= n_d;
            ill_q   <= ill_d;
            icnt_q  <= icnt_d;
        end
    end

    assign cu.pc_write_enable        = pc_we;
    assign cu.pc_source_sel          = pc_sel;
    assign cu.ir_write_enable        = ir_we;
    assign cu.rf_write_enable        = rf_we;
    assign cu.rf_write_dest_sel_addr = dest;
    assign cu.rf_write_data_sel      = data_sel;
    assign cu.alu_op_sel             = alu_op;
    assign cu.alu_b_src_sel          = b_src;
    assign cu.halted                 = (state_q == S_HALT);
    assign cu.illegal_op             = ill_q;
    assign cu.z_flag                 = z_q;
    assign cu.n_flag                 = n_q;
    assign cu.instr_count            = icnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level model plus literal spot checks.
module tb_control_unit;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ir_we;
        logic       rf_we;
        logic [2:0] dest;
        logic [1:0] dsel;
        logic [2:0] alu;
        logic       bsrc;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_unit_if #(.ICNT_W(16)) bus ();
    control_unit #(.LR_ADDR(3'd7), .ICNT_W(16)) dut (.clk(clk), .reset(reset), .cu(bus));

    int   vectors = 0;
    int   miscompares = 0;
    logic chk_en = 1'b0;
    ctl_t exp_c;
    logic m_z, m_n, m_ill;
    int   m_cnt;
    ctl_t last;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t idle_ctl(input logic [2:0] rd);
        ctl_t c = '0;
        c.dest = rd;
        return c;
    endfunction

    function automatic ctl_t fetch_ctl(input logic [2:0] rd, input logic ready);
        ctl_t c = idle_ctl(rd);
        c.ir_we = ready;
        c.pc_we = ready;
        return c;
    endfunction

    // Instruction semantics: what EXECUTE must drive for each opcode.
    function automatic ctl_t exec_ctl(input logic [3:0] op, input logic [2:0] rd,
                                      input logic z, input logic n);
        ctl_t c = idle_ctl(rd);
        case (op)
            4'h1: begin c.rf_we = 1; c.dsel = 2'b01; end
            4'h2: begin c.rf_we = 1; c.alu = 3'b010; end
            4'h3: begin c.rf_we = 1; c.alu = 3'b000; end
            4'h4: begin c.rf_we = 1; c.alu = 3'b001; end
            4'h5: c.alu = 3'b011;
            4'h6: if (z) begin c.pc_we = 1; c.pc_sel = 2'b01; end
            4'h7: if (n) begin c.pc_we = 1; c.pc_sel = 2'b01; end
            4'h8: begin c.pc_we = 1; c.pc_sel = 2'b01; end
            4'h9: begin c.rf_we = 1; c.dest = 3'd7; c.dsel = 2'b10; c.pc_we = 1; c.pc_sel = 2'b11; end
            4'hA: begin c.pc_we = 1; c.pc_sel = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_we",    32'(bus.pc_write_enable),        32'(exp_c.pc_we));
            check("pc_sel",   32'(bus.pc_source_sel),          32'(exp_c.pc_sel));
            check("ir_we",    32'(bus.ir_write_enable),        32'(exp_c.ir_we));
            check("rf_we",    32'(bus.rf_write_enable),        32'(exp_c.rf_we));
            check("dest",     32'(bus.rf_write_dest_sel_addr), 32'(exp_c.dest));
            check("data_sel", 32'(bus.rf_write_data_sel),      32'(exp_c.dsel));
            check("alu_op",   32'(bus.alu_op_sel),             32'(exp_c.alu));
            check("b_src",    32'(bus.alu_b_src_sel),          32'(exp_c.bsrc));
            check("halted",   32'(bus.halted),                 32'(exp_c.halted));
            check("illegal",  32'(bus.illegal_op),             32'(m_ill));
            check("z_flag",   32'(bus.z_flag),                 32'(m_z));
            check("n_flag",   32'(bus.n_flag),                 32'(m_n));
            check("count",    32'(bus.instr_count),            32'(m_cnt));
        end
    end

    task automatic model_reset();
        m_z = 0; m_n = 0; m_ill = 0; m_cnt = 0;
        exp_c = idle_ctl(bus.rd_addr_in);
    endtask

    // Holds reset for the given cycles, releases it and returns at the start of the first FETCH.
    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        repeat (cycles) step();
        reset = 1'b0;
        step();
    endtask

    // Runs one instruction starting in FETCH; returns in the next FETCH (or in HALT for 4'hF).
    task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, input logic zf, input logic nf);
        bus.opcode_in  = op;
        bus.rd_addr_in = rd;
        exp_c = fetch_ctl(rd, 1'b1);
        step();
        exp_c = idle_ctl(rd);
        step();
        if (op == 4'hF) begin
            exp_c.halted = 1'b1;
            return;
        end
        bus.zero_flag_in     = zf;
        bus.negative_flag_in = nf;
        exp_c = exec_ctl(op, rd, m_z, m_n);
        #1;
        last.pc_we  = bus.pc_write_enable;
        last.pc_sel = bus.rf_write_enable ? bus.pc_source_sel : bus.pc_source_sel;
        last.rf_we  = bus.rf_write_enable;
        last.dest   = bus.rf_write_dest_sel_addr;
        last.dsel   = bus.rf_write_data_sel;
        last.alu    = bus.alu_op_sel;
        step();
        m_cnt = (m_cnt + 1) % 65536;
        if (op >= 4'hB && op <= 4'hE) m_ill = 1'b1;
        if (op == 4'h5) begin
            m_z = zf;
            m_n = nf;
        end
        // Live flags now disagree with the latched ones; branches must ignore them.
        bus.zero_flag_in     = ~zf;
        bus.negative_flag_in = ~nf;
    endtask

    initial begin
        reset = 1'b1;
        bus.opcode_in = 4'h0;
        bus.rd_addr_in = 3'd0;
        bus.zero_flag_in = 1'b0;
        bus.negative_flag_in = 1'b0;
`ifdef CU_IMEM_WAIT_EN
        bus.imem_ready = 1'b1;
`endif
        model_reset();
        chk_en = 1'b1;
        apply_reset(3);
        check("first_fetch_ir", 32'(bus.ir_write_enable), 32'd1);
        check("first_fetch_pc", 32'(bus.pc_write_enable), 32'd1);

        do_instr(4'h1, 3'd2, 0, 0);
        check("load_rf_we", 32'(last.rf_we), 32'd1);
        check("load_dsel",  32'(last.dsel),  32'd1);
        check("load_dest",  32'(last.dest),  32'd2);
        do_instr(4'h3, 3'd2, 0, 0);
        check("add_alu",    32'(last.alu),   32'd0);
        check("add_dsel",   32'(last.dsel),  32'd0);
        check("count_2",    32'(bus.instr_count), 32'd2);

        do_instr(4'h5, 3'd1, 1, 0);
        check("cmp_z1",     32'(bus.z_flag), 32'd1);
        do_instr(4'h6, 3'd0, 0, 0);
        check("beq_taken",  32'(last.pc_we), 32'd1);
        check("beq_sel",    32'(last.pc_sel), 32'd1);
        do_instr(4'h5, 3'd1, 0, 1);
        do_instr(4'h6, 3'd0, 1, 1);
        check("beq_not_taken", 32'(last.pc_we), 32'd0);
        do_instr(4'h7, 3'd0, 0, 0);
        check("blt_taken",  32'(last.pc_we), 32'd1);

        do_instr(4'h9, 3'd3, 0, 0);
        check("call_rf_we", 32'(last.rf_we), 32'd1);
        check("call_dest",  32'(last.dest),  32'd7);
        check("call_dsel",  32'(last.dsel),  32'd2);
        check("call_pc_we", 32'(last.pc_we), 32'd1);
        check("call_sel",   32'(last.pc_sel), 32'd3);
        do_instr(4'hA, 3'd3, 0, 0);
        check("ret_pc_we",  32'(last.pc_we), 32'd1);
        check("ret_sel",    32'(last.pc_sel), 32'd2);

        do_instr(4'h2, 3'd5, 0, 0);
        do_instr(4'h4, 3'd6, 1, 1);
        do_instr(4'h8, 3'd1, 0, 0);
        do_instr(4'h0, 3'd4, 1, 0);
        check("count_13",   32'(bus.instr_count), 32'd13);

        // Reset in the middle of an ADD EXECUTE with both flags set.
        do_instr(4'h5, 3'd1, 1, 1);
        bus.opcode_in  = 4'h3;
        bus.rd_addr_in = 3'd4;
        exp_c = fetch_ctl(3'd4, 1'b1);
        step();
        exp_c = idle_ctl(3'd4);
        step();
        exp_c = exec_ctl(4'h3, 3'd4, m_z, m_n);
        #1;
        check("mid_exec_rf_we", 32'(bus.rf_write_enable), 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rf_we", 32'(bus.rf_write_enable), 32'd0);
        check("async_z",     32'(bus.z_flag),          32'd0);
        check("async_n",     32'(bus.n_flag),          32'd0);
        check("async_count", 32'(bus.instr_count),     32'd0);
        repeat (2) step();
        reset = 1'b0;
        step();

`ifdef CU_IMEM_WAIT_EN
        bus.imem_ready = 1'b0;
        exp_c = fetch_ctl(bus.rd_addr_in, 1'b0);
        repeat (4) step();
        check("wait_ir_we", 32'(bus.ir_write_enable), 32'd0);
        bus.imem_ready = 1'b1;
`endif

        do_instr(4'hC, 3'd2, 0, 0);
        check("illegal_set", 32'(bus.illegal_op),  32'd1);
        check("count_1",     32'(bus.instr_count), 32'd1);
        do_instr(4'hF, 3'd0, 0, 0);
        repeat (10) step();
        check("halt_hold",   32'(bus.halted), 32'd1);
        apply_reset(2);
        check("rst_halted",  32'(bus.halted),     32'd0);
        check("rst_illegal", 32'(bus.illegal_op), 32'd0);
        do_instr(4'h1, 3'd3, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM sequencer that drives every control input of the CPU datapath.
- Consumes the datapath's decoded opcode, target-register field and ALU flags.
- Sequences FETCH/DECODE/EXECUTE, holds the latched status flags, and counts retired instructions.
- Sits directly upstream of the datapath; the datapath has no other source of control.

Parameters:
- LR_ADDR, 3'd7: register index used as link register for CALL writes.
- ICNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode_in  input  4  IR[31:28] from datapath.
- rd_addr_in  input  3  IR[27:25] (Rx/Rd) from datapath.
- zero_flag_in  input  1  ALU zero, combinational from datapath.
- negative_flag_in  input  1  ALU negative, combinational from datapath.
- pc_write_enable  output  1  PC load strobe.
- pc_source_sel  output  2  00 PC+1, 01 branch target, 10 LR (RET), 11 call target.
- ir_write_enable  output  1  IR load strobe.
- rf_write_enable  output  1  register-file write strobe.
- rf_write_dest_sel_addr  output  3  write address: rd_addr_in, or LR_ADDR for CALL.
- rf_write_data_sel  output  2  00 ALU, 01 immediate, 10 PC.
- alu_op_sel  output  3  000 ADD, 001 XOR, 010 PASS_B, 011 SUB; others unused.
- alu_b_src_sel  output  1  0 = Ry, 1 = immediate.
- halted  output  1  high in HALT state.
- illegal_op  output  1  sticky; set on an undefined opcode.
- z_flag  output  1  latched zero status.
- n_flag  output  1  latched negative status.
- instr_count  output  ICNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXECUTE, HALT. After reset release the FSM enters FETCH on the next edge. CPI is 3.
- FETCH: assert ir_write_enable=1, pc_write_enable=1, pc_source_sel=00. IR and PC update on the same edge, so the PC already points to the next instruction during DECODE/EXECUTE. Go to DECODE.
- DECODE: all strobes 0. Go to HALT if opcode_in=4'hF, otherwise to EXECUTE.
- EXECUTE: one cycle, then FETCH. Opcode actions:
  - 0 NOP: no writes.
  - 1 LOAD: rf_we=1, data_sel=01, dest=rd.
  - 2 MOV: alu=010, b_src=0, rf_we=1, data_sel=00, dest=rd.
  - 3 ADD: alu=000, b_src=0, rf_we=1, data_sel=00, dest=rd.
  - 4 XOR: alu=001, b_src=0, rf_we=1, data_sel=00, dest=rd.
  - 5 CMP: alu=011, b_src=0, no RF write; latch z_flag/n_flag from the flag inputs.
  - 6 BEQ: if z_flag, pc_we=1, sel=01.
  - 7 BLT: if n_flag, pc_we=1, sel=01.
  - 8 JMP: pc_we=1, sel=01.
  - 9 CALL: rf_we=1, dest=LR_ADDR, data_sel=10, pc_we=1, sel=11. The LR write and PC load happen on the same edge; LR receives the pre-update PC.
  - A RET: pc_we=1, sel=10.
  - B..E: treated as NOP; set illegal_op.
- Flags update only on CMP EXECUTE. Branches use the latched flags, never the live inputs.
- Default outputs whenever a strobe is not asserted: pc_source_sel=00, rf_write_data_sel=00, alu_op_sel=000, alu_b_src_sel=0, rf_write_dest_sel_addr=rd_addr_in.
- instr_count increments at the end of every EXECUTE. It wraps at 2^ICNT_W to 0. HALT does not count.
- HALT: absorbing, all strobes 0, halted=1. Exit only via reset.
- Reset, at any time including mid-EXECUTE: state=FETCH-pending (first FETCH on the first edge after deassertion), all strobes 0, z_flag=0, n_flag=0, illegal_op=0, instr_count=0, halted=0. Any in-flight write is abandoned.
- All strobe outputs are combinational from state + opcode_in + latched flags. They must be glitch-free relative to clk, i.e. sampled only at edges.

Optional Feature:
- Macro: CU_IMEM_WAIT_EN.
- Defined: adds input imem_ready (1 bit). FETCH asserts ir_write_enable and pc_write_enable only while imem_ready=1, and remains in FETCH while imem_ready=0. Reset behaviour is unchanged.
- Undefined: no such port; FETCH always lasts exactly 1 cycle.

Test Plan:
- Reset held 3 cycles, then released → first edge shows ir_we=1, pc_we=1, sel=00; all strobes 0 during reset; instr_count=0.
- LOAD (op 1, rd=2), ADD (op 3, rd=2) → EXECUTE of LOAD: rf_we=1, data_sel=01, dest=2; EXECUTE of ADD: alu=000, data_sel=00; instr_count=2 after 6 cycles.
- CMP with zero_flag_in=1, then BEQ → z_flag=1 after CMP; BEQ EXECUTE gives pc_we=1, sel=01. Repeat with zero_flag_in=0 → BEQ gives pc_we=0.
- CALL, then RET → CALL EXECUTE: rf_we=1, dest=7, data_sel=10, pc_we=1, sel=11; RET EXECUTE: pc_we=1, sel=10.
- Opcode 4'hC, then 4'hF → illegal_op=1 and counter +1 for C; F reaches HALT after DECODE, halted=1 with no strobes for 10 cycles; reset clears both flags.
- Reset asserted during EXECUTE of ADD → rf_we drops immediately (async), z_flag=n_flag=0; with CU_IMEM_WAIT_EN and imem_ready=0 for 4 cycles, FETCH holds with ir_we=0.
